// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//
// Load-use and memory-wait hazard controller for the pipelined core. It sits
// beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM write
// enables plus the bubble (stall_flush) and IF/ID flush controls.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall performance
// counters lu_bubble_cnt and mem_freeze_cnt.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ex_mem_read, ex_rt    EX-stage load and its destination register
//   id_rs, id_rt, id_op   ID-stage register fields and opcode
//   id_valid              ID holds a real instruction
//   mem_busy              data memory cannot complete this cycle
//   ex_branch_taken       branch resolved taken in EX
//   pc_write_en, ifid_write_en, idex_write_en, exmem_write_en
//                         pipeline register write enables
//   stall_flush           load a bubble into ID/EX
//   ifid_flush            clear IF/ID to a bubble
//   lu_active             FSM is in LU_STALL
//   mem_timeout           sticky memory watchdog flag
//   lu_bubble_cnt, mem_freeze_cnt  (HAZARD_PERF_CNT_EN only) saturating counters
//
// State table
//   RUN      | normal flow; a load-use hazard here inserts the first bubble
//   LU_STALL | remaining load-use bubbles, counted down by cnt

module hazard_stall_unit #(
    parameter int              REG_AW      = 4,
    parameter int              OP_W        = 3,
    parameter int              LU_BUBBLES  = 1,
    parameter logic [OP_W-1:0] OP_NRT_A    = 3'b101,
    parameter logic [OP_W-1:0] OP_NRT_B    = 3'b001,
    parameter int              MEM_TIMEOUT = 255,
    parameter int              CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [OP_W-1:0]   id_op,
    input  logic              id_valid,
    input  logic              mem_busy,
    input  logic              ex_branch_taken,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              idex_write_en,
    output logic              exmem_write_en,
    output logic              stall_flush,
    output logic              ifid_flush,
    output logic              lu_active,
    output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  lu_bubble_cnt,
    output logic [CNT_W-1:0]  mem_freeze_cnt
`endif
);

    localparam int            BUSY_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(MEM_TIMEOUT);
    localparam logic [2:0]    LU_CNT_INIT  = 3'(LU_BUBBLES - 1);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } stateT;

    stateT             state, stateNext;
    logic [2:0]        cnt, cntNext;
    logic [BUSY_W-1:0] busyCnt, busyCntNext;
    logic              memTimeoutQ;
    logic              hz;
    logic              pcWe, ifidWe, idexWe, exmemWe, sFlush, iFlush;

    // rt is only a source when the ID opcode does not write it.
    always_comb begin
        hz = id_valid & ex_mem_read &
             ((ex_rt == id_rs) |
              ((ex_rt == id_rt) & (id_op != OP_NRT_A) & (id_op != OP_NRT_B)));
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pcWe      = 1'b1;
        ifidWe    = 1'b1;
        idexWe    = 1'b1;
        exmemWe   = 1'b1;
        sFlush    = 1'b0;
        iFlush    = 1'b0;

        if (mem_busy) begin
            // Freeze: nothing moves, bubbles are not consumed.
            pcWe    = 1'b0;
            ifidWe  = 1'b0;
            idexWe  = 1'b0;
            exmemWe = 1'b0;
        end else if (ex_branch_taken) begin
            // The dependent instruction is squashed, so any stall is moot.
            iFlush    = 1'b1;
            sFlush    = 1'b1;
            stateNext = RUN;
            cntNext   = 3'd0;
        end else if (state == LU_STALL) begin
            pcWe    = 1'b0;
            ifidWe  = 1'b0;
            sFlush  = 1'b1;
            cntNext = cnt - 3'd1;
            if (cnt == 3'd1) begin
                stateNext = RUN;
            end
        end else if (hz) begin
            pcWe   = 1'b0;
            ifidWe = 1'b0;
            sFlush = 1'b1;
            if (LU_BUBBLES > 1) begin
                stateNext = LU_STALL;
                cntNext   = LU_CNT_INIT;
            end
        end
    end

    always_comb begin
        busyCntNext = '0;
        if (mem_busy) begin
            busyCntNext = (busyCnt == BUSY_LIMIT) ? busyCnt : busyCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= 3'd0;
            busyCnt     <= '0;
            memTimeoutQ <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            busyCnt <= busyCntNext;
            if (busyCntNext == BUSY_LIMIT) begin
                memTimeoutQ <= 1'b1;
            end
        end
    end

    // Reset overrides the controls so the pipeline is free-running in reset.
    assign pc_write_en    = pcWe    | ~rst_n;
    assign ifid_write_en  = ifidWe  | ~rst_n;
    assign idex_write_en  = idexWe  | ~rst_n;
    assign exmem_write_en = exmemWe | ~rst_n;
    assign stall_flush    = sFlush  & rst_n;
    assign ifid_flush     = iFlush  & rst_n;
    assign lu_active      = (state == LU_STALL) & rst_n;
    assign mem_timeout    = memTimeoutQ;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] luBubbleQ, memFreezeQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            luBubbleQ  <= '0;
            memFreezeQ <= '0;
        end else begin
            if (sFlush && !ex_branch_taken && !(&luBubbleQ)) begin
                luBubbleQ <= luBubbleQ + 1'b1;
            end
            if (mem_busy && !(&memFreezeQ)) begin
                memFreezeQ <= memFreezeQ + 1'b1;
            end
        end
    end

    assign lu_bubble_cnt  = luBubbleQ;
    assign mem_freeze_cnt = memFreezeQ;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Two instances share all inputs: dutA (1 bubble, long watchdog) and
// dutB (3 bubbles, watchdog of 4). Each step drives inputs at the falling
// edge, queues the expected output vectors, and compares them shortly after.
// Vector layout: {pc, ifid, idex, exmem, stall_flush, ifid_flush, lu_active, mem_timeout}

module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_mem_read;
    logic [3:0] ex_rt, id_rs, id_rt;
    logic [2:0] id_op;
    logic       id_valid, mem_busy, ex_branch_taken;

    logic aPc, aIfid, aIdex, aExmem, aSf, aIf, aLu, aMto;
    logic bPc, bIfid, bIdex, bExmem, bSf, bIf, bLu, bMto;
    logic [7:0] obsA, obsB;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] aLuCnt, aFrzCnt, bLuCnt, bFrzCnt;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.LU_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(2)) dutA (
        .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op), .id_valid(id_valid),
        .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
        .pc_write_en(aPc), .ifid_write_en(aIfid), .idex_write_en(aIdex),
        .exmem_write_en(aExmem), .stall_flush(aSf), .ifid_flush(aIf),
        .lu_active(aLu), .mem_timeout(aMto)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_bubble_cnt(aLuCnt), .mem_freeze_cnt(aFrzCnt)
`endif
    );

    hazard_stall_unit #(.LU_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op), .id_valid(id_valid),
        .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
        .pc_write_en(bPc), .ifid_write_en(bIfid), .idex_write_en(bIdex),
        .exmem_write_en(bExmem), .stall_flush(bSf), .ifid_flush(bIf),
        .lu_active(bLu), .mem_timeout(bMto)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_bubble_cnt(bLuCnt), .mem_freeze_cnt(bFrzCnt)
`endif
    );

    assign obsA = {aPc, aIfid, aIdex, aExmem, aSf, aIf, aLu, aMto};
    assign obsB = {bPc, bIfid, bIdex, bExmem, bSf, bIf, bLu, bMto};

    localparam logic [7:0] RUNO = 8'b1111_0000;
    localparam logic [7:0] RUNT = 8'b1111_0001;
    localparam logic [7:0] BUB0 = 8'b0011_1000;
    localparam logic [7:0] BUB1 = 8'b0011_1010;
    localparam logic [7:0] FRZ0 = 8'b0000_0000;
    localparam logic [7:0] FRZ1 = 8'b0000_0010;
    localparam logic [7:0] BRA  = 8'b1111_1100;
    localparam logic [7:0] BRL  = 8'b1111_1110;

    typedef struct {
        string      tag;
        logic [7:0] expA;
        logic [7:0] expB;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic step(input string tag, input logic rst, input logic mr,
                        input logic [3:0] ert, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [2:0] op, input logic vld, input logic busy,
                        input logic br, input logic [7:0] eA, input logic [7:0] eB);
        expT e;
        @(negedge clk);
        rst_n           = rst;
        ex_mem_read     = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        id_op           = op;
        id_valid        = vld;
        mem_busy        = busy;
        ex_branch_taken = br;
        e.tag  = tag;
        e.expA = eA;
        e.expB = eB;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        assert (obsA === e.expA) else begin
            errors++;
            $error("FAIL %s dutA observed %b expected %b", e.tag, obsA, e.expA);
        end
        checks++;
        assert (obsB === e.expB) else begin
            errors++;
            $error("FAIL %s dutB observed %b expected %b", e.tag, obsB, e.expB);
        end
    endtask

    // Shorthands: idle inputs, a rs load-use hazard on r5, and a busy cycle.
    task automatic idle(input string tag, input logic rst, input logic [7:0] eA, input logic [7:0] eB);
        step(tag, rst, 1'b0, 4'd0, 4'd1, 4'd2, 3'b000, 1'b1, 1'b0, 1'b0, eA, eB);
    endtask

    task automatic haz(input string tag, input logic rst, input logic [7:0] eA, input logic [7:0] eB);
        step(tag, rst, 1'b1, 4'd5, 4'd5, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0, eA, eB);
    endtask

    task automatic busy(input string tag, input logic [7:0] eA, input logic [7:0] eB);
        step(tag, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 3'b000, 1'b1, 1'b1, 1'b0, eA, eB);
    endtask

    initial begin
        rst_n = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        id_op = '0; id_valid = 1'b0; mem_busy = 1'b0; ex_branch_taken = 1'b0;

        // reset forces free-running outputs, even with a hazard present
        idle("rst_idle",  1'b0, RUNO, RUNO);
        haz ("rst_force", 1'b0, RUNO, RUNO);
        idle("rst_rel",   1'b1, RUNO, RUNO);

        // basic load-use on rs
        haz ("lu_b0",  1'b1, BUB0, BUB0);
        idle("lu_b1",  1'b1, RUNO, BUB1);
        idle("lu_b2",  1'b1, RUNO, BUB1);
        idle("lu_end", 1'b1, RUNO, RUNO);

        // rt is a destination for lw/xori, a source otherwise
        step("nrt_lw",   1'b1, 1'b1, 4'd3, 4'd7, 4'd3, 3'b101, 1'b1, 1'b0, 1'b0, RUNO, RUNO);
        step("nrt_xori", 1'b1, 1'b1, 4'd3, 4'd7, 4'd3, 3'b001, 1'b1, 1'b0, 1'b0, RUNO, RUNO);
        step("rt_novld", 1'b1, 1'b1, 4'd3, 4'd7, 4'd3, 3'b000, 1'b0, 1'b0, 1'b0, RUNO, RUNO);
        step("rt_stall", 1'b1, 1'b1, 4'd3, 4'd7, 4'd3, 3'b000, 1'b1, 1'b0, 1'b0, BUB0, BUB0);
        idle("rt_b1", 1'b1, RUNO, BUB1);
        idle("rt_b2", 1'b1, RUNO, BUB1);

        // freeze in the middle of a stall preserves the bubble count
        haz ("frz_b0", 1'b1, BUB0, BUB0);
        busy("frz_1",  FRZ0, FRZ1);
        busy("frz_2",  FRZ0, FRZ1);
        idle("frz_b1", 1'b1, RUNO, BUB1);
        idle("frz_b2", 1'b1, RUNO, BUB1);
        idle("frz_end", 1'b1, RUNO, RUNO);

        // taken branch in the second stall cycle aborts the stall
        haz ("br_b0", 1'b1, BUB0, BUB0);
        step("br_take", 1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 3'b000, 1'b1, 1'b0, 1'b1, BRA, BRL);
        idle("br_after", 1'b1, RUNO, RUNO);

        // watchdog trips in dutB after 4 busy cycles, sticky until reset
        busy("wd_1", FRZ0, FRZ0);
        busy("wd_2", FRZ0, FRZ0);
        busy("wd_3", FRZ0, FRZ0);
        busy("wd_4", FRZ0, FRZ0);
        idle("wd_set",   1'b1, RUNO, RUNT);
        idle("wd_stick", 1'b1, RUNO, RUNT);
        idle("wd_rst",   1'b0, RUNO, RUNT);
        idle("wd_clr",   1'b1, RUNO, RUNO);

        // reset abandons an in-progress stall
        haz ("rs_b0",  1'b1, BUB0, BUB0);
        idle("rs_rst", 1'b0, RUNO, RUNO);
        idle("rs_run", 1'b1, RUNO, RUNO);

        // run for the performance counters (also checks outputs)
        haz ("pf_1", 1'b1, BUB0, BUB0);
        busy("pf_2", FRZ0, FRZ1);
        idle("pf_3", 1'b1, RUNO, BUB1);
        idle("pf_4", 1'b1, RUNO, BUB1);
        haz ("pf_5", 1'b1, BUB0, BUB0);
        idle("pf_6", 1'b1, RUNO, BUB1);
        idle("pf_7", 1'b1, RUNO, BUB1);
        idle("pf_8", 1'b1, RUNO, RUNO);

`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (aLuCnt === 2'd2) else begin
            errors++;
            $error("FAIL perf_luA observed %0d expected %0d", aLuCnt, 2);
        end
        checks++;
        assert (bLuCnt === 2'd3) else begin
            errors++;
            $error("FAIL perf_luB observed %0d expected %0d", bLuCnt, 3);
        end
        checks++;
        assert (aFrzCnt === 2'd1) else begin
            errors++;
            $error("FAIL perf_frzA observed %0d expected %0d", aFrzCnt, 1);
        end
        checks++;
        assert (bFrzCnt === 2'd1) else begin
            errors++;
            $error("FAIL perf_frzB observed %0d expected %0d", bFrzCnt, 1);
        end
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty observed %0d expected %0d", sb.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised load-use and memory-wait hazard controller for the pipelined core. It sits beside the ID stage and drives the write enables of PC, IF/ID, ID/EX and EX/MEM, plus the bubble and flush controls. Relative to the single-bubble stall logic it replaces, it adds:
- configurable load-use bubble count;
- whole-pipeline freeze on data-memory busy, with a sticky watchdog;
- branch-flush arbitration;
- optional stall performance counters.

## Interface
Parameters:
- REG_AW, 4: register address width.
- OP_W, 3: opcode width.
- LU_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..7.
- OP_NRT_A, 3'b101 (lw): opcode whose rt is a destination, not a source.
- OP_NRT_B, 3'b001 (xori): second opcode whose rt is a destination, not a source.
- MEM_TIMEOUT, 255: consecutive mem_busy cycles that trip the watchdog; must be ≥1.
- CNT_W, 16: width of the performance counters.

Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- ex_mem_read, in, 1: the EX-stage instruction is a load.
- ex_rt, in, REG_AW: destination register of the EX-stage load.
- id_rs, in, REG_AW: ID-stage source register rs.
- id_rt, in, REG_AW: ID-stage register rt.
- id_op, in, OP_W: ID-stage opcode.
- id_valid, in, 1: ID holds a real (non-bubble) instruction.
- mem_busy, in, 1: data memory cannot complete this cycle.
- ex_branch_taken, in, 1: a branch resolved taken in EX.
- pc_write_en, out, 1: PC write enable.
- ifid_write_en, out, 1: IF/ID write enable.
- idex_write_en, out, 1: ID/EX write enable.
- exmem_write_en, out, 1: EX/MEM write enable.
- stall_flush, out, 1: load a bubble into ID/EX.
- ifid_flush, out, 1: clear IF/ID to a bubble.
- lu_active, out, 1: FSM is in LU_STALL.
- mem_timeout, out, 1: sticky watchdog flag.

## Operation
Hazard term, combinational:
- hz = id_valid & ex_mem_read & (ex_rt==id_rs | (ex_rt==id_rt & id_op!=OP_NRT_A & id_op!=OP_NRT_B)).

FSM has two states, RUN and LU_STALL, with a 3-bit bubble counter `cnt`. Per-cycle priority, highest first:
- **mem_busy=1 (freeze):**
  - All four write enables are 0; stall_flush=0; ifid_flush=0.
  - State and cnt hold.
- **ex_branch_taken=1 (flush):**
  - pc_write_en=1, ifid_write_en=1, idex_write_en=1, exmem_write_en=1, ifid_flush=1, stall_flush=1.
  - Next state is RUN and cnt is cleared, aborting any load-use stall because the dependent instruction is squashed.
- **State LU_STALL:**
  - pc_write_en=0, ifid_write_en=0, stall_flush=1; idex_write_en and exmem_write_en stay 1.
  - cnt decrements each cycle. When cnt==1, the next state is RUN.
- **State RUN with hz=1:**
  - Same outputs as LU_STALL.
  - If LU_BUBBLES>1: go to LU_STALL with cnt=LU_BUBBLES-1. Otherwise stay in RUN.
- **Otherwise:**
  - All write enables 1; both flushes 0.

hz is ignored while in LU_STALL, because the load has already left EX.

Watchdog:
- A busy counter increments on each mem_busy=1 cycle and clears on any mem_busy=0 cycle. It saturates at MEM_TIMEOUT.
- mem_timeout is set in the cycle after the busy counter reaches MEM_TIMEOUT.
- mem_timeout is sticky and clears only on reset.

## Timing
- Stall outputs are combinational from the current state and inputs; the first bubble is inserted in the same cycle hz is seen.
- A load-use hazard costs exactly LU_BUBBLES cycles of pc_write_en=0, not counting freeze cycles.
- A mem_busy freeze extends a load-use stall without consuming bubbles.
- Reset is synchronous. On the first clk edge with rst_n=0:
  - state=RUN, cnt=0, busy counter=0, mem_timeout=0, perf counters=0.
  - While rst_n=0, outputs are forced: write enables 1, stall_flush=0, ifid_flush=0, lu_active=0.
- Reset during LU_STALL or a freeze abandons the stall at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds the following output ports:
  - lu_bubble_cnt, out, CNT_W: counts cycles with stall_flush=1 and ex_branch_taken=0.
  - mem_freeze_cnt, out, CNT_W: counts mem_busy=1 cycles.
  - Both counters saturate at all-ones and clear on reset.
- HAZARD_PERF_CNT_EN undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- **Basic load-use:** LU_BUBBLES=1; ex_mem_read=1, ex_rt=5, id_rs=5, id_op=3'b000 → pc_write_en=0, stall_flush=1 for 1 cycle; lu_active stays 0.
- **rt exemption:** ex_rt=3, id_rt=3, id_rs=7, id_op=3'b101 or 3'b001 → no stall. Same with id_op=3'b000 → stall.
- **Multi-bubble with freeze:** LU_BUBBLES=3; hazard, then mem_busy=1 for 2 cycles mid-stall → exactly 3 bubble cycles. During the freeze all write enables are 0; total pc hold is 5 cycles.
- **Branch abort:** ex_branch_taken=1 in the second cycle of a 3-bubble stall → ifid_flush=1, pc_write_en=1; next cycle is RUN with lu_active=0.
- **Watchdog:** MEM_TIMEOUT=4; mem_busy high for 4 cycles → mem_timeout=1 from cycle 5. It stays 1 after mem_busy drops and clears only after rst_n=0 at an edge.
- **Perf counters:** with HAZARD_PERF_CNT_EN, CNT_W=2, run 5 bubble cycles → lu_bubble_cnt saturates at 3.
